// File: rtl/rr_arb_lock.sv
// Round-robin arbiter with per-requester grant locking and a bounded hold count.
// The grant is combinational from req and state; priority rotates to the requester after the last winner.
module rr_arb_lock #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N-1:0]   lock,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id,
    output logic           locked
);

    // With MAX_HOLD = 0 the counter only needs to saturate, so any width works.
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 8;

    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] owner_q, owner_d;
    logic           locked_q, locked_d;
    logic [HW-1:0]  holdCnt_q, holdCnt_d;

    logic           found;
    logic [IDW-1:0] winIdx;
    logic [IDW-1:0] cand;
    logic           ownerStays;
    logic [HW-1:0]  holdBase;
    logic           holdOk;

    always_comb begin
        found  = 1'b0;
        winIdx = '0;
        cand   = '0;
        if (locked_q && req[owner_q]) begin
            found  = 1'b1;
            winIdx = owner_q;
        end else begin
            for (int k = 0; k < N; k++) begin
                cand = IDW'((int'(ptr_q) + k) % N);
                if (!found && req[cand]) begin
                    found  = 1'b1;
                    winIdx = cand;
                end
            end
        end
        if (rst) begin
            found  = 1'b0;
            winIdx = '0;
        end
    end

    // A lock run only continues when the current owner is the one being re-granted;
    // any other winner (including after an abandoned lock) starts a fresh run.
    always_comb begin
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        locked_d   = 1'b0;
        holdCnt_d  = '0;
        ownerStays = locked_q && (winIdx == owner_q);
        holdBase   = ownerStays ? holdCnt_q : '0;
        holdOk     = 1'b0;
        if (found) begin
            ptr_d  = (winIdx == IDW'(N - 1)) ? '0 : winIdx + 1'b1;
            holdOk = (MAX_HOLD == 0) || (int'(holdBase) + 1 < MAX_HOLD);
            if (lock[winIdx] && holdOk) begin
                locked_d  = 1'b1;
                owner_d   = winIdx;
                holdCnt_d = (&holdBase) ? holdBase : holdBase + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_q     <= '0;
            owner_q   <= '0;
            locked_q  <= 1'b0;
            holdCnt_q <= '0;
        end else begin
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            locked_q  <= locked_d;
            holdCnt_q <= holdCnt_d;
        end
    end

    assign gnt       = found ? (N'(1) << winIdx) : '0;
    assign gnt_valid = found;
    assign gnt_id    = found ? winIdx : '0;
    assign locked    = locked_q;

endmodule

// File: tb/tb_rr_arb_lock.sv
// Bench for rr_arb_lock: directed vector table, a mid-cycle request change, and
// randomized traffic compared against a streak-counting reference model.
module tb_rr_arb_lock;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
    localparam int IDW      = $clog2(N);

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;
    logic           locked;

    int checks   = 0;
    int failures = 0;

    // Reference model state: who gets priority, who holds a lock, and how long the run is.
    int mPrio   = 0;
    int mHolder = -1;
    int mStreak = 0;

    typedef struct {
        logic         rst;
        logic [N-1:0] req;
        logic [N-1:0] lock;
        int           expId;
        logic         expValid;
        logic         expLocked;
        string        name;
    } vec_t;

    vec_t vecs[$];

    rr_arb_lock #(.N(N), .MAX_HOLD(MAX_HOLD)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .lock     (lock),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_id   (gnt_id),
        .locked   (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk);
        @(negedge clk);
        rst  = r;
        req  = rq;
        lock = lk;
        #1;
    endtask

    function automatic int modelGrant();
        if (rst || req == '0) return -1;
        if (mHolder >= 0 && req[mHolder]) return mHolder;
        for (int k = 0; k < N; k++) begin
            if (req[(mPrio + k) % N]) return (mPrio + k) % N;
        end
        return -1;
    endfunction

    function automatic void modelAdvance(input int g);
        int run;
        if (rst || g < 0) begin
            if (rst) mPrio = 0;
            mHolder = -1;
            mStreak = 0;
            return;
        end
        mPrio = (g + 1) % N;
        run   = (mHolder == g) ? mStreak + 1 : 1;
        if (lock[g] && (MAX_HOLD == 0 || run < MAX_HOLD)) begin
            mHolder = g;
            mStreak = run;
        end else begin
            mHolder = -1;
            mStreak = 0;
        end
    endfunction

    task automatic checkInvariants();
        checkOutput("inv_onehot", int'($onehot0(gnt)), 1);
        checkOutput("inv_gnt_implies_req", int'(gnt & ~req), 0);
        checkOutput("inv_valid_or", int'(gnt_valid), int'(|gnt));
        if (gnt_valid) checkOutput("inv_id_matches_gnt", int'(gnt), int'(N'(1) << gnt_id));
        else           checkOutput("inv_id_zero_idle", int'(gnt_id), 0);
    endtask

    task automatic checkAgainstModel(input string tag);
        int g;
        g = modelGrant();
        checkOutput({tag, "_valid"}, int'(gnt_valid), (g >= 0) ? 1 : 0);
        checkOutput({tag, "_id"}, int'(gnt_id), (g >= 0) ? g : 0);
        checkOutput({tag, "_gnt"}, int'(gnt), (g >= 0) ? (1 << g) : 0);
        checkOutput({tag, "_locked"}, int'(locked), (!rst && mHolder >= 0) ? 1 : 0);
        checkInvariants();
        modelAdvance(g);
    endtask

    function automatic void addVec(input logic r, input logic [N-1:0] rq, input logic [N-1:0] lk,
                                   input int id, input logic v, input logic l, input string nm);
        vec_t e;
        e.rst = r; e.req = rq; e.lock = lk;
        e.expId = id; e.expValid = v; e.expLocked = l; e.name = nm;
        vecs.push_back(e);
    endfunction

    initial begin
        rst  = 1'b1;
        req  = '0;
        lock = '0;

        // Plain rotation with all requesters active.
        addVec(1, 4'b1111, 4'b0000, 0, 0, 0, "rot_reset");
        addVec(0, 4'b1111, 4'b0000, 0, 1, 0, "rot_c0");
        addVec(0, 4'b1111, 4'b0000, 1, 1, 0, "rot_c1");
        addVec(0, 4'b1111, 4'b0000, 2, 1, 0, "rot_c2");
        addVec(0, 4'b1111, 4'b0000, 3, 1, 0, "rot_c3");
        addVec(0, 4'b1111, 4'b0000, 0, 1, 0, "rot_c4");
        addVec(0, 4'b1111, 4'b0000, 1, 1, 0, "rot_c5");
        // Sparse requests, pointer wrap.
        addVec(1, 4'b0101, 4'b0000, 0, 0, 0, "sparse_reset");
        addVec(0, 4'b0101, 4'b0000, 0, 1, 0, "sparse_c0");
        addVec(0, 4'b0101, 4'b0000, 2, 1, 0, "sparse_c1");
        addVec(0, 4'b0101, 4'b0000, 0, 1, 0, "sparse_c2");
        addVec(0, 4'b0101, 4'b0000, 2, 1, 0, "sparse_c3");
        // Requester 1 locks continuously; hold limit of 4 grants.
        addVec(1, 4'b1111, 4'b0010, 0, 0, 0, "hold_reset");
        addVec(0, 4'b1111, 4'b0010, 0, 1, 0, "hold_c0");
        addVec(0, 4'b1111, 4'b0010, 1, 1, 0, "hold_c1");
        addVec(0, 4'b1111, 4'b0010, 1, 1, 1, "hold_c2");
        addVec(0, 4'b1111, 4'b0010, 1, 1, 1, "hold_c3");
        addVec(0, 4'b1111, 4'b0010, 1, 1, 1, "hold_c4");
        addVec(0, 4'b1111, 4'b0010, 2, 1, 0, "hold_c5");
        addVec(0, 4'b1111, 4'b0010, 3, 1, 0, "hold_c6");
        addVec(0, 4'b1111, 4'b0010, 0, 1, 0, "hold_c7");
        addVec(0, 4'b1111, 4'b0010, 1, 1, 0, "hold_c8");
        // Lone locking requester regains the grant after hitting the limit.
        addVec(1, 4'b0010, 4'b0010, 0, 0, 0, "lone_reset");
        addVec(0, 4'b0010, 4'b0010, 1, 1, 0, "lone_c0");
        addVec(0, 4'b0010, 4'b0010, 1, 1, 1, "lone_c1");
        addVec(0, 4'b0010, 4'b0010, 1, 1, 1, "lone_c2");
        addVec(0, 4'b0010, 4'b0010, 1, 1, 1, "lone_c3");
        addVec(0, 4'b0010, 4'b0010, 1, 1, 0, "lone_c4");
        addVec(0, 4'b0010, 4'b0010, 1, 1, 1, "lone_c5");
        // Owner drops its request while locked.
        addVec(1, 4'b1111, 4'b0010, 0, 0, 0, "abandon_reset");
        addVec(0, 4'b1111, 4'b0010, 0, 1, 0, "abandon_c0");
        addVec(0, 4'b1111, 4'b0010, 1, 1, 0, "abandon_c1");
        addVec(0, 4'b1111, 4'b0010, 1, 1, 1, "abandon_c2");
        addVec(0, 4'b1101, 4'b0010, 2, 1, 1, "abandon_drop");
        addVec(0, 4'b1101, 4'b0010, 3, 1, 0, "abandon_after");
        // Reset in the middle of a lock run.
        addVec(1, 4'b1111, 4'b0010, 0, 0, 0, "midrst_reset");
        addVec(0, 4'b1111, 4'b0010, 0, 1, 0, "midrst_c0");
        addVec(0, 4'b1111, 4'b0010, 1, 1, 0, "midrst_c1");
        addVec(0, 4'b1111, 4'b0010, 1, 1, 1, "midrst_c2");
        addVec(1, 4'b1111, 4'b0010, 0, 0, 0, "midrst_assert");
        addVec(0, 4'b1111, 4'b0000, 0, 1, 0, "midrst_release");
        // Idle cycles keep the pointer.
        addVec(1, 4'b0100, 4'b0000, 0, 0, 0, "idle_reset");
        addVec(0, 4'b0100, 4'b0000, 2, 1, 0, "idle_grant2");
        addVec(0, 4'b0000, 4'b0000, 0, 0, 0, "idle_c0");
        addVec(0, 4'b0000, 4'b0000, 0, 0, 0, "idle_c1");
        addVec(0, 4'b0000, 4'b0000, 0, 0, 0, "idle_c2");
        addVec(0, 4'b1111, 4'b0000, 3, 1, 0, "idle_resume");

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].rst, vecs[i].req, vecs[i].lock);
            checkOutput({vecs[i].name, "_id"}, int'(gnt_id), vecs[i].expId);
            checkOutput({vecs[i].name, "_valid"}, int'(gnt_valid), int'(vecs[i].expValid));
            checkOutput({vecs[i].name, "_gnt"}, int'(gnt),
                        vecs[i].expValid ? (1 << vecs[i].expId) : 0);
            checkOutput({vecs[i].name, "_locked"}, int'(locked), int'(vecs[i].expLocked));
            checkInvariants();
        end

        // Request change inside a cycle only moves the combinational grant.
        applyStimulus(1'b1, 4'b1111, 4'b0000);
        applyStimulus(1'b0, 4'b1111, 4'b0000);
        checkOutput("midcyc_first_id", int'(gnt_id), 0);
        #1;
        req = 4'b1100;
        #1;
        checkOutput("midcyc_changed_id", int'(gnt_id), 2);
        checkOutput("midcyc_locked", int'(locked), 0);
        applyStimulus(1'b0, 4'b1111, 4'b0000);
        checkOutput("midcyc_next_id", int'(gnt_id), 3);

        // Randomized traffic against the reference model.
        applyStimulus(1'b1, '0, '0);
        checkAgainstModel("rand_reset");
        for (int c = 0; c < 600; c++) begin
            logic         r;
            logic [N-1:0] rq;
            logic [N-1:0] lk;
            r  = ($urandom_range(0, 60) == 0);
            rq = N'($urandom);
            lk = N'($urandom | $urandom);
            applyStimulus(r, rq, lk);
            checkAgainstModel("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
